pe_lsu: RTL and testbench

- Per-PE load/store unit of the CGRA; sits directly upstream of the PE ALU.
- Turns LOAD/STR opcodes into single-word TCDM-style transactions (req/gnt/rvalid).
- Returns the load result on load_data_o with a one-cycle data_req_valid_o pulse. The ALU consumes these on its LOAD path.
- Raises lsu_busy_o so the PE controller stalls while a transaction is outstanding.

---
 rtl/pe_lsu.sv | 168 ++++++++++++++++
 tb/tb_pe_lsu.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_lsu.sv
// rtl/pe_lsu.sv - per-PE load/store unit: LOAD/STR to single-word TCDM req/gnt/rvalid; grant timeout under PE_LSU_TIMEOUT_EN
`timescale 1ns/1ps
module pe_lsu #(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Exec_En_Global,
    input  logic              LSU_En,
    input  logic [5:0]        Opcode,
    input  logic [DWIDTH-1:0] Addr_In,
    input  logic [DWIDTH-1:0] Store_Data_In,
    output logic              data_req_o,
    output logic [AWIDTH-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i,
    output logic [31:0]       load_data_o,
    output logic              data_req_valid_o,
    output logic              lsu_busy_o,
    output logic              err_o
);

    localparam logic [5:0] OP_LOAD = 6'b000111;
    localparam logic [5:0] OP_STR  = 6'b001001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              timeout_hit;
    logic [AWIDTH-1:0] addr_ext;
    logic [31:0]       wdata_ext;
    logic [AWIDTH-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [31:0]       load_data_q;
    logic              valid_q;

    // Commands are only taken while idle; anything presented while busy is dropped.
    assign accept = (state == S_IDLE) && Exec_En_Global && LSU_En &&
                    ((Opcode == OP_LOAD) || (Opcode == OP_STR));

    generate
        if (AWIDTH > DWIDTH) begin : g_addr_zext
            assign addr_ext = {{(AWIDTH-DWIDTH){1'b0}}, Addr_In};
        end else begin : g_addr_trunc
            assign addr_ext = Addr_In[AWIDTH-1:0];
        end
        if (DWIDTH >= 32) begin : g_wdata_low
            assign wdata_ext = Store_Data_In[31:0];
        end else begin : g_wdata_zext
            assign wdata_ext = {{(32-DWIDTH){1'b0}}, Store_Data_In};
        end
    endgenerate

`ifdef PE_LSU_TIMEOUT_EN
    localparam int              CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tmo_cnt;
    logic          err_q;

    // Grant-wait counter: cleared when a command enters REQ, counts REQ cycles without grant.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (accept) begin
                tmo_cnt <= '0;
            end else if ((state == S_REQ) && !data_gnt_i) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // A grant arriving in the final cycle still wins over the timeout.
    assign timeout_hit = (state == S_REQ) && !data_gnt_i && (tmo_cnt == CNT_LAST);
    assign err_o       = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
    assign timeout_hit        = 1'b0;
    assign err_o              = 1'b0;
`endif

    // State register; busy and request are decoded from it so they are effectively registered.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: rvalid is only meaningful in WAIT, so a late response after reset is ignored.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_REQ;
            S_REQ: begin
                if (data_gnt_i) begin
                    state_next = S_WAIT;
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: if (data_rvalid_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        data_req_o = 1'b0;
        lsu_busy_o = 1'b0;
        if (state == S_REQ) begin
            data_req_o = 1'b1;
        end
        if (state != S_IDLE) begin
            lsu_busy_o = 1'b1;
        end
    end

    // Command capture and load-result register; the valid pulse lasts one cycle since it is cleared every cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            load_data_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                addr_q  <= addr_ext;
                wdata_q <= wdata_ext;
                we_q    <= (Opcode == OP_STR);
            end
            if ((state == S_WAIT) && data_rvalid_i && !we_q) begin
                load_data_q <= data_rdata_i;
                valid_q     <= 1'b1;
            end
            if (timeout_hit) begin
                load_data_q <= '0;
                valid_q     <= !we_q;
            end
        end
    end

    assign data_addr_o      = addr_q;
    assign data_we_o        = we_q;
    assign data_wdata_o     = wdata_q;
    assign load_data_o      = load_data_q;
    assign data_req_valid_o = valid_q;

endmodule

// File: tb/tb_pe_lsu.sv
// tb/tb_pe_lsu.sv - randomized scoreboard bench for pe_lsu with memory-model responder
`timescale 1ns/1ps
module tb_pe_lsu;

    localparam logic [5:0] OP_LOAD = 6'b000111;
    localparam logic [5:0] OP_STR  = 6'b001001;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Exec_En_Global = 1'b1;
    logic        LSU_En = 1'b0;
    logic [5:0]  Opcode = 6'h0;
    logic [31:0] Addr_In = 32'h0;
    logic [31:0] Store_Data_In = 32'h0;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'h0;
    logic [31:0] load_data_o;
    logic        data_req_valid_o;
    logic        lsu_busy_o;
    logic        err_o;

    pe_lsu #(.DWIDTH(32), .AWIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .Clk(Clk), .Reset(Reset), .Exec_En_Global(Exec_En_Global), .LSU_En(LSU_En),
        .Opcode(Opcode), .Addr_In(Addr_In), .Store_Data_In(Store_Data_In),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .load_data_o(load_data_o),
        .data_req_valid_o(data_req_valid_o), .lsu_busy_o(lsu_busy_o), .err_o(err_o)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] data; logic err; } rsp_t;

    req_t        req_q[$];
    rsp_t        load_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pulse_cnt = 0;
    int   busy_cyc = 0;
    int   prev_pulse_cyc = 0;
    int   last_pulse_cyc = 0;
    int   done_cnt = 0;
    int   gnt_cnt = 0;
    int   gnt_delay_cfg = -1;
    int   rv_delay_cfg = -1;
    bit   gnt_block = 1'b0;
    bit   prev_valid = 1'b0;
    logic [31:0] exp_last_load = 32'h0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ref_mem[a] = d;
        slv_mem[a] = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk); #1;
        end
    endtask

    // Present one command for one cycle; the model decides acceptance from the command rules alone.
    task automatic issue(input bit ex, input bit en, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input bit tmo, output bit acc);
        rsp_t r;
        req_t q;
        acc = ex && en && ((op == OP_LOAD) || (op == OP_STR));
        if (acc) begin
            if (!tmo) begin
                q.addr = a; q.we = (op == OP_STR); q.wdata = wd;
                req_q.push_back(q);
            end
            if (op == OP_LOAD) begin
                r.data = tmo ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : 32'h0);
                r.err  = tmo;
                load_q.push_back(r);
                exp_last_load = r.data;
            end else if (!tmo) begin
                ref_mem[a] = wd;
            end
        end
        Exec_En_Global = ex; LSU_En = en; Opcode = op; Addr_In = a; Store_Data_In = wd;
        @(posedge Clk); #1;
        Exec_En_Global = 1'b1; LSU_En = 1'b0; Opcode = 6'h0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int k = 0;
        while ((done_cnt == d0) && (k < 200)) begin
            @(posedge Clk); #1;
            k++;
        end
        check(name, done_cnt != d0, 1);
    endtask

    always @(posedge Clk) cyc++;

    // Memory responder: grants after a delay, answers from its own memory, checks each granted request.
    initial begin
        int gcnt = -1;
        int rcnt = 0;
        bit in_wait = 1'b0;
        logic [31:0] a = 32'h0;
        logic [31:0] wd = 32'h0;
        logic w = 1'b0;
        req_t q;
        forever begin
            @(negedge Clk);
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = $urandom;
            if (in_wait) begin
                if (rcnt == 0) begin
                    data_rvalid_i = 1'b1;
                    if (w) slv_mem[a] = wd;
                    else data_rdata_i = slv_mem.exists(a) ? slv_mem[a] : 32'h0;
                    in_wait = 1'b0;
                    done_cnt++;
                end else begin
                    rcnt--;
                end
            end else if (data_req_o === 1'b1) begin
                if (gcnt < 0) gcnt = (gnt_delay_cfg >= 0) ? gnt_delay_cfg : int'($urandom_range(0, 4));
                if (!gnt_block && (gcnt == 0)) begin
                    data_gnt_i = 1'b1;
                    gnt_cnt++;
                    a = data_addr_o; w = data_we_o; wd = data_wdata_o;
                    check("req_expected", req_q.size() > 0, 1);
                    if (req_q.size() > 0) begin
                        q = req_q.pop_front();
                        check("req_addr", data_addr_o, q.addr);
                        check("req_we", data_we_o, q.we);
                        if (q.we) check("req_wdata", data_wdata_o, q.wdata);
                    end
                    rcnt = (rv_delay_cfg >= 0) ? rv_delay_cfg : int'($urandom_range(0, 2));
                    in_wait = 1'b1;
                    gcnt = -1;
                end else begin
                    if (gcnt > 0) gcnt--;
                    data_rvalid_i = 1'($urandom_range(0, 1));
                end
            end else begin
                gcnt = -1;
            end
        end
    end

    // Load-result monitor: pops the scoreboard on every valid pulse.
    always @(negedge Clk) begin
        rsp_t e;
        if (data_req_valid_o === 1'b1) begin
            pulse_cnt++;
            prev_pulse_cyc = last_pulse_cyc;
            last_pulse_cyc = cyc;
            if (prev_valid) check("valid_single_cycle", 0, 1);
            check("pulse_expected", load_q.size() > 0, 1);
            if (load_q.size() > 0) begin
                e = load_q.pop_front();
                check("load_data", load_data_o, e.data);
                check("load_err", err_o, e.err);
            end
        end else if (err_o !== 1'b0) begin
            check("err_without_pulse", err_o, 0);
        end
        if (lsu_busy_o === 1'b1) busy_cyc++;
        prev_valid = (data_req_valid_o === 1'b1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        bit acc;
        int n;
        int e;
        int p0;
        int b0;
        int d0;
        int g0;

        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        check("rst_ctrl", {data_req_o, lsu_busy_o, data_req_valid_o, err_o, data_we_o}, 5'b0);
        check("rst_load_data", load_data_o, 32'h0);
        check("rst_addr_wdata", {data_addr_o, data_wdata_o}, 64'h0);
        @(posedge Clk); #1;

        // basic load
        preload(32'h100, 32'hDEADBEEF);
        gnt_delay_cfg = 0; rv_delay_cfg = 0;
        b0 = busy_cyc; p0 = pulse_cnt; d0 = done_cnt;
        issue(1, 1, OP_LOAD, 32'h100, 32'h0, 0, acc);
        wait_done("basic_done", d0);
        idle(2);
        check("basic_busy_cycles", busy_cyc - b0, 2);
        check("basic_pulses", pulse_cnt - p0, 1);
        check("basic_load_data", load_data_o, 32'hDEADBEEF);

        // reset during WAIT, response arrives after release
        preload(32'h40, 32'h12345678);
        rv_delay_cfg = 4; p0 = pulse_cnt; d0 = done_cnt;
        issue(1, 1, OP_LOAD, 32'h40, 32'h0, 0, acc);
        @(posedge Clk); #1 Reset = 1'b0;
        @(posedge Clk); #1 Reset = 1'b1;
        load_q.delete();
        exp_last_load = 32'h0;
        wait_done("rst_late_rvalid", d0);
        idle(2);
        check("rst_mid_busy", lsu_busy_o, 0);
        check("rst_mid_load_data", load_data_o, 32'h0);
        check("rst_mid_pulses", pulse_cnt - p0, 0);
        check("rst_mid_req", data_req_o, 0);

        // store with grant withheld for 5 cycles
        gnt_delay_cfg = 5; rv_delay_cfg = 0; p0 = pulse_cnt; d0 = done_cnt;
        issue(1, 1, OP_STR, 32'h20, 32'h55, 0, acc);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (data_req_o === 1'b1 && data_addr_o == 32'h20 && data_wdata_o == 32'h55 && data_we_o === 1'b1) n++;
        end
        check("stall_stable_cycles", n, 6);
        @(negedge Clk);
        check("stall_req_dropped", data_req_o, 0);
        @(posedge Clk); #1;
        wait_done("stall_done", d0);
        idle(2);
        check("stall_no_pulse", pulse_cnt - p0, 0);
        check("stall_load_data", load_data_o, exp_last_load);

        // busy rejection with global enable toggling
        preload(32'h8, 32'h77);
        gnt_delay_cfg = 0; rv_delay_cfg = 3; p0 = pulse_cnt; d0 = done_cnt; g0 = gnt_cnt;
        issue(1, 1, OP_LOAD, 32'h8, 32'h0, 0, acc);
        @(posedge Clk); #1;
        Exec_En_Global = 1'b0; LSU_En = 1'b1; Opcode = OP_LOAD; Addr_In = 32'h300;
        @(posedge Clk); #1 Exec_En_Global = 1'b1;
        @(posedge Clk); #1 LSU_En = 1'b0; Opcode = 6'h0;
        wait_done("busy_done", d0);
        idle(4);
        check("busy_reject_pulses", pulse_cnt - p0, 1);
        check("busy_reject_grants", gnt_cnt - g0, 1);

        // back-to-back loads
        preload(32'h0, 32'h1);
        preload(32'h4, 32'h2);
        rv_delay_cfg = 0; d0 = done_cnt;
        issue(1, 1, OP_LOAD, 32'h0, 32'h0, 0, acc);
        wait_done("b2b_first", d0);
        d0 = done_cnt;
        issue(1, 1, OP_LOAD, 32'h4, 32'h0, 0, acc);
        wait_done("b2b_second", d0);
        idle(2);
        check("b2b_pulse_gap", last_pulse_cyc - prev_pulse_cyc, 3);
        check("b2b_load_data", load_data_o, 32'h2);

`ifdef PE_LSU_TIMEOUT_EN
        gnt_block = 1'b1; p0 = pulse_cnt;
        issue(1, 1, OP_LOAD, 32'h100, 32'h0, 1, acc);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (data_req_o !== 1'b1) break;
            n++;
        end
        check("tmo_req_cycles", n, 8);
        @(posedge Clk); #1 gnt_block = 1'b0;
        idle(2);
        check("tmo_pulses", pulse_cnt - p0, 1);
        check("tmo_load_data", load_data_o, 32'h0);
`else
        gnt_block = 1'b1; d0 = done_cnt;
        issue(1, 1, OP_LOAD, 32'h100, 32'h0, 0, acc);
        n = 0; e = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (data_req_o === 1'b1) n++;
            if (err_o !== 1'b0) e++;
        end
        check("hold_req_cycles", n, 20);
        check("hold_no_err", e, 0);
        @(posedge Clk); #1 gnt_block = 1'b0;
        wait_done("hold_done", d0);
        idle(2);
`endif

        // randomized traffic
        gnt_delay_cfg = -1; rv_delay_cfg = -1;
        for (int i = 0; i < 80; i++) begin
            logic [5:0]  op;
            logic [31:0] a;
            int          sel;
            sel = int'($urandom_range(0, 9));
            op  = (sel < 4) ? OP_LOAD : ((sel < 8) ? OP_STR : 6'($urandom_range(0, 63)));
            a   = 32'($urandom_range(0, 15)) << 2;
            d0  = done_cnt;
            issue($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, op, a, $urandom, 0, acc);
            if (acc) wait_done("rand_done", d0);
            idle(int'($urandom_range(0, 2)));
        end

        idle(5);
        check("queues_drained", {32'(req_q.size()), 32'(load_q.size())}, 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
